// File: rtl/bus_arbiter_rr2.sv
// Two-master, one-slave bus arbiter: captures strobes into per-master slots,
// grants the slave round-robin (or fixed priority) and sequences each access.
module bus_arbiter_rr2 #(
  parameter int unsigned READ_LAT   = 1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  output logic        grant
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned NM = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  req_t          m_req [NM];
  logic [NM-1:0] m_wr;
  logic [NM-1:0] m_rd;
  logic [NM-1:0] pend;

  state_t        state_q, state_d;
  req_t          slot_q [NM];
  req_t          slot_d [NM];
  logic [NM-1:0] rbusy_q, rbusy_d;
  logic [NM-1:0] wbusy_q, wbusy_d;
  logic [DW-1:0] rdata_q [NM];
  logic [DW-1:0] rdata_d [NM];
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [MW-1:0] s_wmask_q, s_wmask_d;
  logic          s_rstrb_q, s_rstrb_d;
  logic          pick;

  assign m_req[0] = {m0_addr, m0_wdata, m0_wmask};
  assign m_req[1] = {m1_addr, m1_wdata, m1_wmask};
  assign m_wr     = {|m1_wmask, |m0_wmask};
  assign m_rd     = {m1_rstrb, m0_rstrb};
  assign pend     = rbusy_q | wbusy_q;

  // Slot capture, arbitration and transaction sequencing
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    rbusy_d   = rbusy_q;
    wbusy_d   = wbusy_q;
    rdata_d   = rdata_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wmask_d = '0;
    s_rstrb_d = 1'b0;
    pick      = 1'b0;

    // A write wins over a coincident read; strobes into an occupied slot are dropped
    for (int i = 0; i < int'(NM); i++) begin
      if (!pend[i]) begin
        if (m_wr[i]) begin
          slot_d[i]  = m_req[i];
          wbusy_d[i] = 1'b1;
        end else if (m_rd[i]) begin
          slot_d[i]  = m_req[i];
          rbusy_d[i] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pend) begin
          if (&pend) pick = FIXED_PRIO ? 1'b0 : ~last_q;
          else       pick = pend[1];
          gnt_d     = pick;
          last_d    = pick;
          s_addr_d  = slot_q[pick].addr;
          s_wdata_d = slot_q[pick].wdata;
          if (wbusy_q[pick]) s_wmask_d = slot_q[pick].wmask;
          else               s_rstrb_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wbusy_q[gnt_q]) begin
          wbusy_d[gnt_q] = 1'b0;
          state_d        = S_IDLE;
        end else begin
          cnt_d   = CW'(READ_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d[gnt_q] = s_rdata;
          rbusy_d[gnt_q] = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < int'(NM); i++) begin
        slot_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
      rbusy_q   <= '0;
      wbusy_q   <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wmask_q <= '0;
      s_rstrb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      rdata_q   <= rdata_d;
      rbusy_q   <= rbusy_d;
      wbusy_q   <= wbusy_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wmask_q <= s_wmask_d;
      s_rstrb_q <= s_rstrb_d;
    end
  end

  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign m0_rbusy = rbusy_q[0];
  assign m1_rbusy = rbusy_q[1];
  assign m0_wbusy = wbusy_q[0];
  assign m1_wbusy = wbusy_q[1];
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wmask  = s_wmask_q;
  assign s_rstrb  = s_rstrb_q;
  assign grant    = gnt_q;

endmodule
